// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad / one-hot line encoders.
//   kp_state_t    : encoder FSM states (IDLE, DEBOUNCE, HELD, RELEASE)
//   ALL_RELEASED  : idle value of the active-low line bus
//   prio_encode() : lowest-index-low priority encoder
//   multi_low()   : true when more than one line is low
package keypad_pkg;

  localparam int unsigned LINES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [LINES-1:0] ALL_RELEASED = 4'b1111;

  function automatic logic [1:0] prio_encode(input logic [LINES-1:0] lines);
    logic [1:0] code;
    logic       found;
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (!lines[i] && !found) begin
        code  = 2'(i);
        found = 1'b1;
      end
    end
    return code;
  endfunction

  function automatic logic multi_low(input logic [LINES-1:0] lines);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      n = n + {2'b00, ~lines[i]};
    end
    return (n > 3'd1);
  endfunction

endpackage

// File: rtl/keypad_encoder_sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous bus.
//   clk, rst : clock, synchronous active-high reset (flops reset to all-ones)
//   d        : asynchronous input bus
//   q        : d delayed by DEPTH flops
module sync_chain #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= '1;
      end
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronizes, debounces and priority-encodes 4 active-low
// one-hot lines into a 2-bit code.
//   clk, rst    : clock, synchronous active-high reset
//   input_4     : active-low lines (4'b1111 = nothing asserted), asynchronous
//   output_2    : last accepted code (qualified by valid)
//   valid       : high while an accepted press is held
//   press_pulse : one-cycle strobe on an accepted press
//   multi       : more than one line low in the accepted/pending sample
// Optional: define KEYPAD_ENCODER_MULTI_REJECT_EN to refuse multi-low samples.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] input_4,
  output logic [1:0] output_2,
  output logic       valid,
  output logic       press_pulse,
  output logic       multi
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first sees the difference counts as one stable
  // cycle, so RELEASE needs one count fewer than DEBOUNCE.
  localparam logic [CW-1:0] REL_LAST =
    CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

`ifdef KEYPAD_ENCODER_MULTI_REJECT_EN
  localparam bit REJECT_MULTI = 1'b1;
`else
  localparam bit REJECT_MULTI = 1'b0;
`endif

  logic [3:0]    synced;
  kp_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    captured, captured_n;
  logic [1:0]    code_n;
  logic          valid_n, pulse_n, multi_n;

  sync_chain #(
    .WIDTH (4),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (input_4),
    .q   (synced)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      captured    <= ALL_RELEASED;
      output_2    <= '0;
      valid       <= 1'b0;
      press_pulse <= 1'b0;
      multi       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      captured    <= captured_n;
      output_2    <= code_n;
      valid       <= valid_n;
      press_pulse <= pulse_n;
      multi       <= multi_n;
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    captured_n = captured;
    code_n     = output_2;
    valid_n    = valid;
    pulse_n    = 1'b0;
    multi_n    = multi;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        multi_n = 1'b0;
        if (synced != ALL_RELEASED) begin
          captured_n = synced;
          cnt_n      = '0;
          state_n    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (synced == ALL_RELEASED) begin
          multi_n = 1'b0;
          state_n = IDLE;
        end else if (synced != captured) begin
          captured_n = synced;
          cnt_n      = '0;
          multi_n    = 1'b0;
        end else if (cnt == CNT_LAST) begin
          if (REJECT_MULTI && multi_low(captured)) begin
            multi_n = 1'b1;
          end else begin
            state_n = HELD;
            code_n  = prio_encode(captured);
            valid_n = 1'b1;
            pulse_n = 1'b1;
            multi_n = multi_low(captured);
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HELD: begin
        if (synced != captured) begin
          if (SINGLE_CYCLE) begin
            valid_n = 1'b0;
            multi_n = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n   = '0;
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (synced == captured) begin
          state_n = HELD;
        end else if (cnt >= REL_LAST) begin
          valid_n = 1'b0;
          multi_n = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
